// File: rtl/rgb_to_gray_seq.sv
// RGB to gray with one shared multiplier that the FSM steps over R, G, B. out_valid rises 3 edges after accept, one pixel per 4 cycles.
// in_ready is low while converting or while the held result is unconsumed; a result is swapped for a new pixel on the same edge.
module rgb_to_gray_seq #(
  parameter int unsigned M  = 8,
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 8,
  parameter int unsigned CR = 77,
  parameter int unsigned CG = 150,
  parameter int unsigned CB = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] r,
  input  logic [M-1:0] g,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         busy
);
  localparam int unsigned PW = M + CW;
  localparam int unsigned AW = M + CW + 2;
  localparam logic [CW-1:0] CR_C = CW'(CR);
  localparam logic [CW-1:0] CG_C = CW'(CG);
  localparam logic [CW-1:0] CB_C = CW'(CB);
  localparam logic [AW:0]   RND  = (AW+1)'(1) << (CW-1);
  localparam logic [AW:0]   YMAX = (AW+1)'({M{1'b1}});

  typedef enum logic [2:0] {IDLE, MR, MG, MB, OUT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [M-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [N-1:0]  y_q, y_d;
  logic          out_valid_q, out_valid_d;

  logic [CW-1:0] coef;
  logic [M-1:0]  opnd;
  logic [PW-1:0] prod;
  logic [AW-1:0] acc_base, sum;
  logic [AW:0]   s_rnd, yf;
  logic [M-1:0]  ysat;
  logic [N-1:0]  y_scaled;
  logic          in_xfer, out_xfer;

  assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & out_ready);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = (state_q != IDLE);

  // Shared multiplier: the state selects which channel and coefficient feed it.
  always_comb begin
    coef = '0;
    opnd = '0;
    case (state_q)
      MR:      begin coef = CR_C; opnd = r_q; end
      MG:      begin coef = CG_C; opnd = g_q; end
      MB:      begin coef = CB_C; opnd = b_q; end
      default: begin coef = '0;   opnd = '0;  end
    endcase
  end

  assign prod     = PW'(opnd) * PW'(coef);
  assign acc_base = (state_q == MR) ? '0 : acc_q;
  assign sum      = acc_base + AW'(prod);
  // Round half up, clamp to full channel range, then drop low bits for narrower outputs.
  assign s_rnd    = {1'b0, sum} + RND;
  assign yf       = s_rnd >> CW;
  assign ysat     = (yf > YMAX) ? {M{1'b1}} : yf[M-1:0];
  assign y_scaled = N'(ysat >> (M - N));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          r_d     = r;
          g_d     = g;
          b_d     = b;
          state_d = MR;
        end
      end
      MR: begin
        acc_d   = sum;
        state_d = MG;
      end
      MG: begin
        acc_d   = sum;
        state_d = MB;
      end
      MB: begin
        acc_d       = sum;
        y_d         = y_scaled;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          if (in_xfer) begin
            r_d     = r;
            g_d     = g;
            b_d     = b;
            state_d = MR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/rgb_to_gray_seq.md
Name: rgb_to_gray_seq

Overview:
Sequential RGB-to-grayscale converter with valid/ready streaming handshakes on both sides. It uses one shared M-by-CW multiplier and an accumulator. A small FSM time-multiplexes the multiplier over the R, G and B channels, trading throughput for area on iCE40 parts that have no spare DSP or LUT budget for a three-multiplier combinational converter. It sits between a pixel source (camera or video decoder) and any gray-level consumer.

Parameters:
M, 8, input channel width in bits
N, 8, output gray width in bits; legal range 1..M
CW, 8, coefficient fractional bits; channel weight = C/2^CW
CR, 77, red coefficient (unsigned, CW bits)
CG, 150, green coefficient (unsigned, CW bits)
CB, 29, blue coefficient (unsigned, CW bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  r/g/b hold a valid pixel
in_ready  out  1  block accepts a pixel this cycle
r  in  M  red channel
g  in  M  green channel
b  in  M  blue channel
out_valid  out  1  y holds a valid result
out_ready  in  1  consumer takes y this cycle
y  out  N  gray result
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, operand regs=0, y=0, out_valid=0. Any in-flight pixel is discarded and no output is produced for it. in_ready follows its combinational rule (1 in IDLE), but no transfer is counted while rst_n is low.
- Transfers: input transfer = in_valid & in_ready at a rising edge. Output transfer = out_valid & out_ready at a rising edge.
- in_ready (combinational) = (state==IDLE) | (state==OUT & out_ready).
- acc is M+CW+2 bits wide, unsigned. Products are CR*r, CG*g and CB*b, each M+CW bits.
- States:
  - IDLE: on input transfer, latch r/g/b into operand regs and go to MR.
  - MR: acc <= CR*r_q; go to MG.
  - MG: acc <= acc + CG*g_q; go to MB.
  - MB: s = acc + CB*b_q. Set y <= scale(s) and out_valid <= 1; go to OUT.
  - OUT: hold y and out_valid until an output transfer.
    - Output transfer with no input transfer: out_valid <= 0; go to IDLE.
    - Output transfer and input transfer in the same cycle: out_valid <= 0; latch the new operands; go to MR.
    - out_ready low: in_ready=0 and y stays stable.
- scale(s):
  - yf = (s + 2^(CW-1)) >> CW, i.e. round half up.
  - If yf > 2^M-1, yf = 2^M-1 (saturate).
  - y = yf >> (M-N), truncating.
- Timing:
  - Latency: out_valid rises 3 edges after the input-transfer edge.
  - Sustained throughput with out_ready tied high: one pixel per 4 cycles.
- y is not cleared after consumption; it keeps the last value while out_valid=0.
- Input changes outside an input transfer have no effect. Operands are registered at acceptance.
- out_ready is ignored while out_valid=0.
- busy=0 only in IDLE.

Test Plan:
1. Defaults, out_ready=1. Send (0,0,0), (55,55,55), (255,255,255), (255,0,0), (0,255,0), (0,0,255) -> y = 0, 55, 255, 77, 149, 29. Each out_valid rises exactly 3 edges after acceptance.
2. Back-to-back: in_valid held high with 4 distinct pixels, out_ready=1 -> accept on every 4th edge, out_valid high once per 4 cycles, results in order.
3. Backpressure: out_ready=0 after result 77, next pixel presented -> in_ready=0 and y stays 77 for 10 cycles. Raise out_ready for 1 cycle -> output consumed and new pixel accepted on the same edge; its result follows 3 edges later.
4. Saturation: CR=200, CG=150, CB=29 (sum 379), input (255,255,255) -> raw 378, y=255.
5. N=4, M=8, defaults: (255,255,255) -> y=15; (55,55,55) -> y=3.
6. Reset mid-operation: assert rst_n low in state MG -> out_valid=0, y=0, busy=0 immediately. After release, no stale result appears; the next pixel (255,0,0) gives y=77.
